// File: rtl/logisim_io_pkg.sv
// Shared constants and helpers for the Logisim I/O shell.
//   DEF_*   : default parameter values used by the shell and its interface
//   MAX_*   : upper bounds on channel counts the shell is meant to handle
//   cnt_w() : width of a debounce counter that must hold 0..cycles
package logisim_io_pkg;

    localparam int DEF_NUM_IN          = 2;
    localparam int DEF_NUM_OUT         = 1;
    localparam int DEF_DEBOUNCE_CYCLES = 4;
    localparam bit DEF_OUT_REG         = 1'b1;

    // Masks are carried as NUM_IN-wide vectors; these bound the widths.
    localparam int MAX_NUM_IN  = 64;
    localparam int MAX_NUM_OUT = 64;

    function automatic int cnt_w(input int cycles);
        return (cycles < 1) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/logisim_io_shell_if.sv
// Board/circuit side bundle of the Logisim I/O shell.
//   pin_in    : raw board inputs            (master -> slave)
//   core_out  : outputs of the circuit      (master -> slave)
//   core_lvl  : conditioned input levels    (slave  -> master)
//   core_rise : one-cycle rise pulses       (slave  -> master)
//   pin_out   : board output pins           (slave  -> master)
// The shell is the slave; the board/circuit environment is the master.
interface logisim_io_shell_if
    import logisim_io_pkg::*;
#(
    parameter int NUM_IN  = DEF_NUM_IN,
    parameter int NUM_OUT = DEF_NUM_OUT
);
    logic [NUM_IN-1:0]  pin_in;
    logic [NUM_IN-1:0]  core_lvl;
    logic [NUM_IN-1:0]  core_rise;
    logic [NUM_OUT-1:0] core_out;
    logic [NUM_OUT-1:0] pin_out;

    modport master (
        output pin_in,
        output core_out,
        input  core_lvl,
        input  core_rise,
        input  pin_out
    );

    modport slave (
        input  pin_in,
        input  core_out,
        output core_lvl,
        output core_rise,
        output pin_out
    );
endinterface

// File: rtl/logisim_io_debounce.sv
// One input channel: polarity, 2-FF synchroniser, debounce, rise pulse, toggle.
//   i_clk    : system clock
//   i_rst_n  : asynchronous active-low reset
//   i_pin    : raw asynchronous board input
//   o_lvl    : debounced level, or toggle state when TOGGLE=1
//   o_rise   : one-cycle pulse when the debounced level goes 0->1
module logisim_io_debounce
    import logisim_io_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter bit ACTIVE_LOW      = 1'b0,
    parameter bit TOGGLE          = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_pin,
    output logic o_lvl,
    output logic o_rise
);
    localparam int            CW   = cnt_w(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_deb;
    logic          r_rise;
    logic          r_tog;
    logic [CW-1:0] r_cnt;

    logic w_pol;
    logic w_accept;
    logic w_accept_rise;

    assign w_pol         = i_pin ^ ACTIVE_LOW;
    // The synchronised value has disagreed with deb for DEBOUNCE_CYCLES
    // consecutive samples, counting this one.
    assign w_accept      = (r_sync2 != r_deb) && (r_cnt == LAST);
    assign w_accept_rise = w_accept & r_sync2;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_deb   <= 1'b0;
            r_cnt   <= '0;
            r_rise  <= 1'b0;
            r_tog   <= 1'b0;
        end else begin
            r_sync1 <= w_pol;
            r_sync2 <= r_sync1;
            if (r_sync2 == r_deb) begin
                // Stable or a glitch returned to the accepted level.
                r_cnt <= '0;
            end else if (w_accept) begin
                r_deb <= r_sync2;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            // Rise pulse and toggle move on the same edge deb goes high.
            r_rise <= w_accept_rise;
            if (w_accept_rise) begin
                r_tog <= ~r_tog;
            end
        end
    end

    assign o_lvl  = TOGGLE ? r_tog : r_deb;
    assign o_rise = r_rise;

endmodule

// File: rtl/logisim_io_shell.sv
// FPGA top-level I/O shell between board pins and a generated Logisim circuit.
//   fpgaGlobalClock   : system clock
//   fpgaGlobalReset_n : asynchronous active-low reset
//   io (slave)        : pin_in/core_out in, core_lvl/core_rise/pin_out out
// Each input channel is conditioned by its own debounce instance; board
// outputs are either registered once or passed straight through.
module logisim_io_shell
    import logisim_io_pkg::*;
#(
    parameter int                NUM_IN          = DEF_NUM_IN,
    parameter int                NUM_OUT         = DEF_NUM_OUT,
    parameter int                DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter logic [NUM_IN-1:0] IN_ACTIVE_LOW   = '0,
    parameter logic [NUM_IN-1:0] TOGGLE_MASK     = '0,
    parameter bit                OUT_REG         = DEF_OUT_REG
) (
    input  logic               fpgaGlobalClock,
    input  logic               fpgaGlobalReset_n,
    logisim_io_shell_if.slave  io
);
    logic [NUM_IN-1:0] w_lvl;
    logic [NUM_IN-1:0] w_rise;

    for (genvar i = 0; i < NUM_IN; i++) begin : g_ch
        logisim_io_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .ACTIVE_LOW      (IN_ACTIVE_LOW[i]),
            .TOGGLE          (TOGGLE_MASK[i])
        ) u_deb (
            .i_clk   (fpgaGlobalClock),
            .i_rst_n (fpgaGlobalReset_n),
            .i_pin   (io.pin_in[i]),
            .o_lvl   (w_lvl[i]),
            .o_rise  (w_rise[i])
        );
    end

    assign io.core_lvl  = w_lvl;
    assign io.core_rise = w_rise;

    if (OUT_REG) begin : g_out_reg
        logic [NUM_OUT-1:0] r_pin_out;

        always_ff @(posedge fpgaGlobalClock or negedge fpgaGlobalReset_n) begin
            if (!fpgaGlobalReset_n) begin
                r_pin_out <= '0;
            end else begin
                r_pin_out <= io.core_out;
            end
        end

        assign io.pin_out = r_pin_out;
    end else begin : g_out_comb
        assign io.pin_out = io.core_out;
    end

endmodule

// File: tb/tb_logisim_io_shell.sv
module tb_logisim_io_shell;

    localparam int NI = 3;  // number of DUT instances

    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instance configurations: A default, B toggle/active-low/comb out, C D=1.
    int       dcyc [NI] = '{4, 4, 1};
    logic [1:0] alm [NI] = '{2'b00, 2'b10, 2'b01};
    logic [1:0] tmk [NI] = '{2'b00, 2'b01, 2'b10};
    bit       oreg [NI] = '{1'b1, 1'b0, 1'b1};

    logic [1:0] pin  [NI];
    logic       cout [NI];
    logic [1:0] o_lvl  [NI];
    logic [1:0] o_rise [NI];
    logic       o_pout [NI];

    logisim_io_shell_if #(.NUM_IN(2), .NUM_OUT(1)) if_a ();
    logisim_io_shell_if #(.NUM_IN(2), .NUM_OUT(1)) if_b ();
    logisim_io_shell_if #(.NUM_IN(2), .NUM_OUT(1)) if_c ();

    assign if_a.pin_in   = pin[0];
    assign if_a.core_out = cout[0];
    assign if_b.pin_in   = pin[1];
    assign if_b.core_out = cout[1];
    assign if_c.pin_in   = pin[2];
    assign if_c.core_out = cout[2];

    assign o_lvl[0]  = if_a.core_lvl;
    assign o_rise[0] = if_a.core_rise;
    assign o_pout[0] = if_a.pin_out;
    assign o_lvl[1]  = if_b.core_lvl;
    assign o_rise[1] = if_b.core_rise;
    assign o_pout[1] = if_b.pin_out;
    assign o_lvl[2]  = if_c.core_lvl;
    assign o_rise[2] = if_c.core_rise;
    assign o_pout[2] = if_c.pin_out;

    logisim_io_shell #(
        .NUM_IN(2), .NUM_OUT(1), .DEBOUNCE_CYCLES(4),
        .IN_ACTIVE_LOW(2'b00), .TOGGLE_MASK(2'b00), .OUT_REG(1'b1)
    ) u_dut_a (
        .fpgaGlobalClock   (clk),
        .fpgaGlobalReset_n (rst_n),
        .io                (if_a)
    );

    logisim_io_shell #(
        .NUM_IN(2), .NUM_OUT(1), .DEBOUNCE_CYCLES(4),
        .IN_ACTIVE_LOW(2'b10), .TOGGLE_MASK(2'b01), .OUT_REG(1'b0)
    ) u_dut_b (
        .fpgaGlobalClock   (clk),
        .fpgaGlobalReset_n (rst_n),
        .io                (if_b)
    );

    logisim_io_shell #(
        .NUM_IN(2), .NUM_OUT(1), .DEBOUNCE_CYCLES(1),
        .IN_ACTIVE_LOW(2'b01), .TOGGLE_MASK(2'b10), .OUT_REG(1'b1)
    ) u_dut_c (
        .fpgaGlobalClock   (clk),
        .fpgaGlobalReset_n (rst_n),
        .io                (if_c)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string nm, input int k, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[inst %0d] @%0t: got %0h, expected %0h", nm, k, $time, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: per channel, the accepted level changes once the
    // last D synchronised samples all disagree with it.
    // ------------------------------------------------------------------
    typedef struct packed {
        logic [5:0] lvl;
        logic [5:0] rise;
        logic [2:0] pout;
    } exp_t;

    exp_t exp_q[$];

    logic [1:0] m_sy1 [NI];
    logic [1:0] m_sy2 [NI];
    logic [1:0] m_deb [NI];
    logic [1:0] m_tog [NI];
    logic [1:0] m_rise[NI];
    logic       m_pout[NI];
    logic [7:0] m_hist[NI][2];

    always @(posedge clk) begin : model
        exp_t       e;
        logic       s;
        logic       acc;
        logic [1:0] newr;
        e = '0;
        for (int k = 0; k < NI; k++) begin
            if (!rst_n) begin
                m_sy1[k]  = '0;
                m_sy2[k]  = '0;
                m_deb[k]  = '0;
                m_tog[k]  = '0;
                m_rise[k] = '0;
                m_pout[k] = 1'b0;
                m_hist[k][0] = '0;
                m_hist[k][1] = '0;
            end else begin
                newr = '0;
                for (int c = 0; c < 2; c++) begin
                    s = m_sy2[k][c];
                    m_hist[k][c] = {m_hist[k][c][6:0], s};
                    acc = 1'b1;
                    for (int j = 0; j < dcyc[k]; j++)
                        if (m_hist[k][c][j] == m_deb[k][c]) acc = 1'b0;
                    if (acc) begin
                        m_deb[k][c] = s;
                        if (s) begin
                            newr[c] = 1'b1;
                            m_tog[k][c] = ~m_tog[k][c];
                        end
                    end
                end
                m_rise[k] = newr;
                m_sy2[k]  = m_sy1[k];
                m_sy1[k]  = pin[k] ^ alm[k];
                m_pout[k] = cout[k];
            end
            e.lvl[2*k +: 2]  = (m_tog[k] & tmk[k]) | (m_deb[k] & ~tmk[k]);
            e.rise[2*k +: 2] = m_rise[k];
            e.pout[k]        = oreg[k] ? m_pout[k] : cout[k];
        end
        exp_q.push_back(e);
    end

    // Monitor: pops one expectation per clock and compares all outputs.
    always @(posedge clk) begin : monitor
        exp_t e;
        #1;
        if (exp_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL scoreboard @%0t: no expected entry, got 0 required 1", $time);
        end else begin
            e = exp_q.pop_front();
            for (int k = 0; k < NI; k++) begin
                check("core_lvl",  k, {6'b0, o_lvl[k]},  {6'b0, e.lvl[2*k +: 2]});
                check("core_rise", k, {6'b0, o_rise[k]}, {6'b0, e.rise[2*k +: 2]});
                check("pin_out",   k, {7'b0, o_pout[k]}, {7'b0, e.pout[k]});
            end
        end
    end

    // Outputs must clear as soon as reset asserts, without a clock edge.
    task automatic check_async_zero();
        #1;
        for (int k = 0; k < NI; k++) begin
            check("rst_lvl",  k, {6'b0, o_lvl[k]},  8'h00);
            check("rst_rise", k, {6'b0, o_rise[k]}, 8'h00);
            if (oreg[k]) check("rst_pout", k, {7'b0, o_pout[k]}, 8'h00);
        end
    endtask

    task automatic randomize_cout();
        for (int k = 0; k < NI; k++) cout[k] = 1'($urandom_range(0, 1));
    endtask

    initial begin : driver
        logic [4:0] bounce;
        rst_n = 1'b0;
        for (int k = 0; k < NI; k++) begin
            pin[k]  = 2'b11;
            cout[k] = 1'b1;
        end
        check_async_zero();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Inputs held active through reset release.
        repeat (10) begin
            @(negedge clk);
            randomize_cout();
        end

        // Bouncy press on channel 0 of every instance, then stable.
        for (int k = 0; k < NI; k++) pin[k] = 2'b00;
        repeat (8) @(negedge clk);
        bounce = 5'b10101;
        for (int b = 4; b >= 0; b--) begin
            for (int k = 0; k < NI; k++) pin[k][0] = bounce[b];
            @(negedge clk);
        end
        repeat (10) @(negedge clk);

        // Randomised slow-changing inputs with occasional glitches and resets.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int k = 0; k < NI; k++)
                for (int c = 0; c < 2; c++)
                    if ($urandom_range(0, 9) == 0) pin[k][c] = ~pin[k][c];
            randomize_cout();
            if ($urandom_range(0, 299) == 0) begin
                rst_n = 1'b0;
                check_async_zero();
                @(negedge clk);
                rst_n = 1'b1;
            end else begin
                @(negedge clk);
            end
        end

        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
